// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory; holds the CPU in reset until loaded.
// Optional trailing checksum word is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-2:0] load_words,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     cpu_rst,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CW = ADDRESS_WIDTH - 1;
  localparam logic [CW-1:0] MAX_WORDS = CW'(1) << (ADDRESS_WIDTH - 2);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ~ADDRESS_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CSUM;
`else
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  state_t                   state_q;
  logic [1:0]               idx_q;
  logic [CW-1:0]            cnt_q;
  logic [CW-1:0]            target_q;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0]    wr_data_q;
  logic [CW-1:0]            words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]              sum_q;
  logic [31:0]              csum_q;
  logic                     err_q;
`endif

  assign words_d = (load_words > MAX_WORDS) ? MAX_WORDS : load_words;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      target_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
      csum_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            target_q  <= words_d;
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_addr_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q     <= '0;
            err_q     <= 1'b0;
`endif
            state_q   <= (words_d == '0) ? S_AFTER_DATA : S_RECV;
          end
        end
        S_RECV: begin
          if (byte_valid) begin
            wr_data_q[8*idx_q +: 8] <= byte_data;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          cnt_q <= cnt_q + CW'(1);
          idx_q <= '0;
          // Hold at the top word instead of wrapping back to address 0.
          if (wr_addr_q != LAST_ADDR) wr_addr_q <= wr_addr_q + ADDRESS_WIDTH'(4);
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_q <= sum_q + wr_data_q;
`endif
          state_q <= (cnt_q + CW'(1) == target_q) ? S_AFTER_DATA : S_RECV;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (byte_valid) begin
            csum_q[8*idx_q +: 8] <= byte_data;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              err_q   <= ({byte_data, csum_q[23:0]} != sum_q);
              state_q <= S_DONE;
            end
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == S_RECV) || (state_q == S_CSUM);
  assign err        = err_q;
`else
  assign byte_ready = (state_q == S_RECV);
  assign err        = 1'b0;
`endif
  assign busy    = byte_ready || (state_q == S_WRITE);
  assign wr_en   = (state_q == S_WRITE);
  assign done    = (state_q == S_DONE);
  assign cpu_rst = !(done && !err);
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction fetch path (PC register + instruction memory).
- Receives a program as a byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes each word into the instruction memory write port at consecutive word-aligned byte addresses.
- Holds the CPU in reset until the load completes, then releases it so fetch starts at address 0.

Parameters:
ADDRESS_WIDTH, 12, byte-address width of instruction memory; word count capacity is 2^(ADDRESS_WIDTH-2).
DATA_WIDTH, 32, instruction word width; fixed at 32, four bytes per word.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a load
load_words  input  ADDRESS_WIDTH-1  number of words to load, sampled on an accepted start
byte_valid  input  1  byte_data is valid
byte_data  input  8  next program byte
byte_ready  output  1  loader can accept a byte this cycle
wr_en  output  1  instruction memory write strobe
wr_addr  output  ADDRESS_WIDTH  byte address of the write; always a multiple of 4
wr_data  output  DATA_WIDTH  word to write
cpu_rst  output  1  reset to PC/CPU; high while not loaded
busy  output  1  load in progress
done  output  1  load completed
err  output  1  checksum mismatch; constant 0 without the optional feature

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE.
  - cpu_rst=1; done=0, busy=0, byte_ready=0, wr_en=0, err=0.
  - wr_addr=0, wr_data=0; byte index=0, word count=0.
  - Reset asserted mid-load aborts immediately; no further writes occur.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - cpu_rst=1.
  - start -> sample load_words, clamp it to 2^(ADDRESS_WIDTH-2), clear wr_addr and count.
  - If the clamped value is 0, go to DONE; otherwise go to RECV.
- RECV:
  - byte_ready=1, busy=1.
  - A byte is accepted in any cycle with byte_valid && byte_ready.
  - Byte k (k=0..3) is written into wr_data[8k+7:8k]; the first byte goes to the LSB.
  - On the 4th accepted byte, go to WRITE. byte_valid low stalls with no state change.
- WRITE:
  - Lasts exactly 1 cycle: wr_en=1, byte_ready=0, wr_addr and wr_data stable.
  - Next cycle: wr_addr += 4, count += 1, byte index = 0.
  - If the new count equals the clamped load_words, go to DONE; otherwise return to RECV.
- DONE:
  - done=1, busy=0, cpu_rst=0 (the CPU starts fetching at PC=0 the next cycle).
  - start restarts the load as from IDLE; cpu_rst returns to 1 in the cycle after start.
- start while busy (RECV/WRITE) is ignored.
- wr_addr saturates at the last word; the clamp guarantees no wrap-around.
- Throughput: at most one word per 5 cycles (4 byte accepts + 1 WRITE).
- wr_en is never high outside WRITE.
- Output timing: all outputs are registered or decoded from state only; no combinational path from byte_valid to any output.

Optional Feature:
Macro: IMEM_LOADER_CHECKSUM_EN
- Defined:
  - After the last data word, the FSM enters state CSUM and receives 4 more bytes as a little-endian checksum, with no write.
  - The running sum of all loaded words mod 2^32 is compared with the received checksum.
  - Match -> DONE with err=0.
  - Mismatch -> DONE with done=1, err=1, and cpu_rst held at 1.
  - err clears on the next start or on reset.
  - With load_words=0, the checksum word is still received and is expected to be 0.
- Undefined:
  - CSUM state and sum register do not exist; err is tied to 0.

Test Plan:
- Reset then idle 10 cycles -> cpu_rst=1, done=0, wr_en never asserted, byte_ready=0.
- start, load_words=2, bytes 13 00 00 00 93 00 10 00 fed back-to-back:
  - writes (addr 0x000, 0x00000013) and (addr 0x004, 0x00100093);
  - done=1 and cpu_rst=0 on the cycle after the 2nd WRITE.
- Same load with byte_valid deasserted for 3 cycles between every byte -> identical writes; no extra wr_en pulses.
- load_words=0 -> DONE directly, no writes.
  - load_words=1500 (ADDRESS_WIDTH=12) -> exactly 1024 writes, last at 0xFFC.
- Assert rst after the 6th byte of a 4-word load -> all outputs return to reset values within the same cycle; restart loads correctly from 0x000.
- IMEM_LOADER_CHECKSUM_EN, words 0x00000013 and 0x00100093:
  - checksum 0x001000A6 -> err=0, cpu_rst=0;
  - checksum 0x001000A7 -> err=1, cpu_rst=1, done=1.
